player_link_rx: RTL and testbench



---
 rtl/player_link_rx_pkg.sv | 28 ++
 rtl/player_link_rx_sync.sv | 24 ++
 rtl/player_link_rx.sv | 155 +++++++++++++++
 tb/tb_player_link_rx.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/player_link_rx_pkg.sv
// Shared constants and frame layout for the inter-board player link (rx and tx ends).
package player_link_rx_pkg;

  localparam int unsigned LINK_CLKS_PER_BIT   = 521;
  localparam int unsigned LINK_TIMEOUT_CYCLES = 6_000_000;
  localparam logic [1:0]  LINK_MARKER         = 2'b10;

  // Receiver FSM encoding, kept as plain constants for the legacy tools downstream
  typedef logic [2:0] link_rx_state_t;
  localparam link_rx_state_t IDLE      = 3'd0;
  localparam link_rx_state_t START     = 3'd1;
  localparam link_rx_state_t DATA      = 3'd2;
  localparam link_rx_state_t STOP      = 3'd3;
  localparam link_rx_state_t WAIT_IDLE = 3'd4;

  // Frame byte: {marker[1:0], payload[3:0], player2_ready, player1_ready}, LSB sent first
  typedef struct packed {
    logic [1:0] marker;
    logic [3:0] payload;
    logic       p2_ready;
    logic       p1_ready;
  } link_frame_t;

  function automatic logic link_marker_ok(input link_frame_t frame);
    return frame.marker == LINK_MARKER;
  endfunction

endpackage

// File: rtl/player_link_rx_sync.sv
// Two-flop synchroniser for the asynchronous link line; resets to the idle-high level.
module player_link_rx_sync (
  input  logic clk60MHz,
  input  logic rst,
  input  logic i_rx,
  output logic o_rx_s
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk60MHz) begin
    if (rst) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
    end else begin
      r_meta <= i_rx;
      r_sync <= r_meta;
    end
  end

  assign o_rx_s = r_sync;

endmodule

// File: rtl/player_link_rx.sv
// Receive end of the player link: deserialises 8N1 frames carrying the peer's ready flags
// and payload, and tracks link liveness with a frame timeout.
module player_link_rx
  import player_link_rx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT   = LINK_CLKS_PER_BIT,
  parameter int unsigned TIMEOUT_CYCLES = LINK_TIMEOUT_CYCLES
) (
  input  logic       clk60MHz,
  input  logic       rst,
  input  logic       rx,
  output logic       in_player1_ready,
  output logic       in_player2_ready,
  output logic [3:0] rx_data,
  output logic       rx_valid,
  output logic       frame_error,
  output logic       link_up
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned TO_W  = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TO_W-1:0]  TO_MAX    = TO_W'(TIMEOUT_CYCLES - 1);

  logic             w_rx_s;
  link_rx_state_t   r_state;
  link_rx_state_t   w_state_d;
  logic [CNT_W-1:0] r_clk_cnt;
  logic [CNT_W-1:0] w_clk_cnt_d;
  logic [2:0]       r_bit_idx;
  logic [2:0]       w_bit_idx_d;
  link_frame_t      r_shift;
  link_frame_t      w_shift_d;
  logic             w_commit;
  logic             w_error;
  logic [TO_W-1:0]  r_to_cnt;
  logic [TO_W-1:0]  w_to_inc;
  logic             w_to_expire;

  player_link_rx_sync u_sync (
    .clk60MHz (clk60MHz),
    .rst      (rst),
    .i_rx     (rx),
    .o_rx_s   (w_rx_s)
  );

  always_comb begin
    w_state_d   = r_state;
    w_clk_cnt_d = r_clk_cnt + 1'b1;
    w_bit_idx_d = r_bit_idx;
    w_shift_d   = r_shift;
    w_commit    = 1'b0;
    w_error     = 1'b0;
    case (r_state)
      IDLE: begin
        w_clk_cnt_d = '0;
        if (!w_rx_s) w_state_d = START;
      end
      START: begin
        // A start bit that is high again at mid-bit is a glitch, not a frame
        if (r_clk_cnt == HALF_LAST) begin
          w_clk_cnt_d = '0;
          if (w_rx_s) begin
            w_state_d = IDLE;
          end else begin
            w_state_d   = DATA;
            w_bit_idx_d = '0;
          end
        end
      end
      DATA: begin
        if (r_clk_cnt == BIT_LAST) begin
          w_clk_cnt_d          = '0;
          w_shift_d[r_bit_idx] = w_rx_s;
          if (r_bit_idx == 3'd7) w_state_d = STOP;
          else                   w_bit_idx_d = r_bit_idx + 3'd1;
        end
      end
      STOP: begin
        if (r_clk_cnt == BIT_LAST) begin
          w_clk_cnt_d = '0;
          if (w_rx_s && link_marker_ok(r_shift)) begin
            w_commit  = 1'b1;
            w_state_d = IDLE;
          end else begin
            w_error   = 1'b1;
            w_state_d = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        // Line held low (break) parks here so only one error is ever reported
        w_clk_cnt_d = '0;
        if (w_rx_s) w_state_d = IDLE;
      end
      default: begin
        w_clk_cnt_d = '0;
        w_state_d   = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk60MHz) begin
    if (rst) begin
      r_state   <= IDLE;
      r_clk_cnt <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
    end else begin
      r_state   <= w_state_d;
      r_clk_cnt <= w_clk_cnt_d;
      r_bit_idx <= w_bit_idx_d;
      r_shift   <= w_shift_d;
    end
  end

  assign w_to_inc    = (r_to_cnt == TO_MAX) ? r_to_cnt : r_to_cnt + 1'b1;
  assign w_to_expire = (w_to_inc == TO_MAX);

  // A commit coinciding with expiry wins and restarts the timeout
  always_ff @(posedge clk60MHz) begin
    if (rst) begin
      in_player1_ready <= 1'b0;
      in_player2_ready <= 1'b0;
      rx_data          <= '0;
      link_up          <= 1'b0;
      r_to_cnt         <= '0;
    end else if (w_commit) begin
      in_player1_ready <= r_shift.p1_ready;
      in_player2_ready <= r_shift.p2_ready;
      rx_data          <= r_shift.payload;
      link_up          <= 1'b1;
      r_to_cnt         <= '0;
    end else begin
      r_to_cnt <= w_to_inc;
      if (w_to_expire) begin
        link_up          <= 1'b0;
        in_player1_ready <= 1'b0;
        in_player2_ready <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk60MHz) begin
    if (rst) begin
      rx_valid    <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      rx_valid    <= w_commit;
      frame_error <= w_error;
    end
  end

endmodule

// File: tb/tb_player_link_rx.sv
// Directed bench for player_link_rx with a short bit period and timeout.
module tb_player_link_rx;

  localparam int unsigned CPB = 8;
  localparam int unsigned TO  = 1000;

  logic       clk60MHz = 1'b0;
  logic       rst      = 1'b1;
  logic       rx       = 1'b1;
  logic       in_player1_ready;
  logic       in_player2_ready;
  logic [3:0] rx_data;
  logic       rx_valid;
  logic       frame_error;
  logic       link_up;

  int n_checks   = 0;
  int n_fail     = 0;
  int cyc        = 0;
  int valid_cnt  = 0;
  int err_cnt    = 0;
  int both_cnt   = 0;
  int commit_cyc = 0;
  int fall_cyc   = 0;
  logic prev_link_up = 1'b0;

  player_link_rx #(
    .CLKS_PER_BIT   (CPB),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk60MHz         (clk60MHz),
    .rst              (rst),
    .rx               (rx),
    .in_player1_ready (in_player1_ready),
    .in_player2_ready (in_player2_ready),
    .rx_data          (rx_data),
    .rx_valid         (rx_valid),
    .frame_error      (frame_error),
    .link_up          (link_up)
  );

  always #5 clk60MHz = ~clk60MHz;

  always @(posedge clk60MHz) cyc++;

  always @(negedge clk60MHz) begin
    if (rx_valid) begin
      valid_cnt++;
      commit_cyc = cyc;
    end
    if (frame_error) err_cnt++;
    if (rx_valid && frame_error) both_cnt++;
    if (prev_link_up && !link_up) fall_cyc = cyc;
    prev_link_up = link_up;
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk60MHz);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(CPB);
    end
    rx = stop_bit;
    tick(CPB);
  endtask

  initial begin
    int v0;
    int e0;
    logic [7:0] partial;

    tick(3);
    check_eq("rst_p1", int'(in_player1_ready), 0);
    check_eq("rst_p2", int'(in_player2_ready), 0);
    check_eq("rst_data", int'(rx_data), 0);
    check_eq("rst_link", int'(link_up), 0);
    check_eq("rst_valid", int'(rx_valid), 0);
    check_eq("rst_err", int'(frame_error), 0);
    rst = 1'b0;
    tick(4);

    // Valid frame: p1=1, p2=0, payload 6
    v0 = valid_cnt; e0 = err_cnt;
    send_byte(8'b10_0110_01, 1'b1);
    tick(4);
    check_eq("f1_valid_cnt", valid_cnt - v0, 1);
    check_eq("f1_err_cnt", err_cnt - e0, 0);
    check_eq("f1_p1", int'(in_player1_ready), 1);
    check_eq("f1_p2", int'(in_player2_ready), 0);
    check_eq("f1_data", int'(rx_data), 6);
    check_eq("f1_link", int'(link_up), 1);

    // Three-cycle low glitch
    v0 = valid_cnt; e0 = err_cnt;
    rx = 1'b0;
    tick(3);
    rx = 1'b1;
    tick(20);
    check_eq("gl_valid_cnt", valid_cnt - v0, 0);
    check_eq("gl_err_cnt", err_cnt - e0, 0);
    check_eq("gl_p1", int'(in_player1_ready), 1);
    check_eq("gl_data", int'(rx_data), 6);

    // Bad marker
    v0 = valid_cnt; e0 = err_cnt;
    send_byte(8'b01_0000_11, 1'b1);
    tick(4);
    check_eq("bm_err_cnt", err_cnt - e0, 1);
    check_eq("bm_valid_cnt", valid_cnt - v0, 0);
    check_eq("bm_p1", int'(in_player1_ready), 1);
    check_eq("bm_p2", int'(in_player2_ready), 0);
    check_eq("bm_data", int'(rx_data), 6);
    check_eq("bm_link", int'(link_up), 1);

    // Stop bit 0 followed by a 50-cycle break
    v0 = valid_cnt; e0 = err_cnt;
    send_byte(8'b10_0101_10, 1'b0);
    tick(50);
    rx = 1'b1;
    tick(20);
    check_eq("brk_err_cnt", err_cnt - e0, 1);
    check_eq("brk_valid_cnt", valid_cnt - v0, 0);
    check_eq("brk_data", int'(rx_data), 6);
    v0 = valid_cnt;
    send_byte(8'b10_0101_10, 1'b1);
    tick(4);
    check_eq("ab_valid_cnt", valid_cnt - v0, 1);
    check_eq("ab_p1", int'(in_player1_ready), 0);
    check_eq("ab_p2", int'(in_player2_ready), 1);
    check_eq("ab_data", int'(rx_data), 5);

    // Both ready, then silence past the timeout
    send_byte(8'b10_1010_11, 1'b1);
    tick(4);
    check_eq("to_p1_pre", int'(in_player1_ready), 1);
    check_eq("to_p2_pre", int'(in_player2_ready), 1);
    check_eq("to_data_pre", int'(rx_data), 10);
    tick(1100);
    check_eq("to_link", int'(link_up), 0);
    check_eq("to_p1", int'(in_player1_ready), 0);
    check_eq("to_p2", int'(in_player2_ready), 0);
    check_eq("to_data_hold", int'(rx_data), 10);
    check_eq("to_fall_delay", fall_cyc - commit_cyc, TO - 1);

    // Reset in the middle of data bit 4
    partial = 8'b10_0001_01;
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 4; i++) begin
      rx = partial[i];
      tick(CPB);
    end
    rx = partial[4];
    tick(CPB / 2);
    v0 = valid_cnt; e0 = err_cnt;
    rst = 1'b1;
    rx  = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(20);
    check_eq("mr_valid_cnt", valid_cnt - v0, 0);
    check_eq("mr_link", int'(link_up), 0);
    send_byte(8'b10_1111_10, 1'b1);
    tick(4);
    check_eq("mr2_valid_cnt", valid_cnt - v0, 1);
    check_eq("mr2_err_cnt", err_cnt - e0, 0);
    check_eq("mr2_p1", int'(in_player1_ready), 0);
    check_eq("mr2_p2", int'(in_player2_ready), 1);
    check_eq("mr2_data", int'(rx_data), 15);
    check_eq("mr2_link", int'(link_up), 1);

    check_eq("valid_err_overlap", both_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
